// File: rtl/inst_loader.sv
// Program buffer feeding inst_mem: collects a host program, replays it as one
// gap-free burst, then holds off the next program until inst_mem has executed it.
module inst_loader #(
  parameter int unsigned INST_W = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned DELAY  = 16,
  parameter int unsigned GUARD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [INST_W-1:0] s_data,
  input  logic              s_last,
  output logic              inst_in_v,
  output logic [INST_W-1:0] inst_in,
  output logic              busy,
  output logic              err_len
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned WW    = AW + 6;

  typedef enum logic [1:0] {FILL, DRAIN, BURST, EXEC} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       len_q, len_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                armed_q, armed_d;
  logic                s_ready_q, s_ready_d;
  logic                inst_in_v_q, inst_in_v_d;
  logic [INST_W-1:0]   inst_in_q, inst_in_d;
  logic                busy_q, busy_d;
  logic                err_len_q, err_len_d;
  logic                beat_c;
  logic                mem_we_c;
  logic [INST_W-1:0]   mem_q [DEPTH];

  assign beat_c = s_valid & s_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    wait_d      = wait_q;
    armed_d     = armed_q;
    inst_in_v_d = 1'b0;
    inst_in_d   = inst_in_q;
    err_len_d   = err_len_q;
    mem_we_c    = 1'b0;

    case (state_q)
      FILL: begin
        if (beat_c) begin
          mem_we_c = 1'b1;
          count_d  = count_q + CW'(1);
          if (s_last) begin
            state_d = BURST;
            len_d   = count_q + CW'(1);
          end else if (count_q == CW'(DEPTH - 1)) begin
            state_d   = DRAIN;
            len_d     = CW'(DEPTH);
            err_len_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat_c && s_last) state_d = BURST;
      end
      BURST: begin
        // One idle cycle after the s_last edge before the first beat
        if (!armed_q) begin
          armed_d = 1'b1;
        end else begin
          inst_in_v_d = 1'b1;
          inst_in_d   = mem_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + AW'(1);
          if ((CW'(rd_ptr_q) + CW'(1)) == len_q) begin
            state_d = EXEC;
            armed_d = 1'b0;
            wait_d  = WW'(DELAY) + WW'(len_q) + WW'(GUARD);
          end
        end
      end
      EXEC: begin
        if (wait_q == '0) begin
          state_d  = FILL;
          count_d  = '0;
          rd_ptr_d = '0;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: state_d = FILL;
    endcase

    s_ready_d = (state_d == FILL) || (state_d == DRAIN);
    busy_d    = (state_d != FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      count_q     <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      wait_q      <= '0;
      armed_q     <= 1'b0;
      s_ready_q   <= 1'b1;
      inst_in_v_q <= 1'b0;
      inst_in_q   <= '0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      wait_q      <= wait_d;
      armed_q     <= armed_d;
      s_ready_q   <= s_ready_d;
      inst_in_v_q <= inst_in_v_d;
      inst_in_q   <= inst_in_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
    end
  end

  // Program storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[count_q[AW-1:0]] <= s_data;
  end

  assign s_ready   = s_ready_q;
  assign inst_in_v = inst_in_v_q;
  assign inst_in   = inst_in_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: burst timing, gaps, EXEC hold-off, truncation,
// single-beat program and reset during a burst.
module tb_inst_loader;

  localparam int unsigned INST_W = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DELAY  = 16;
  localparam int unsigned GUARD  = 2;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [INST_W-1:0] s_data;
  logic              s_last;
  logic              inst_in_v;
  logic [INST_W-1:0] inst_in;
  logic              busy;
  logic              err_len;

  int tests = 0;
  int fails = 0;

  inst_loader #(.INST_W(INST_W), .AW(AW), .DELAY(DELAY), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .inst_in_v (inst_in_v),
    .inst_in   (inst_in),
    .busy      (busy),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input logic [INST_W-1:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called at the negedge after the s_last handshake edge.
  task automatic check_burst(input string tag, input logic [INST_W-1:0] base, input int len);
    check({tag, "_v_edge0"}, 32'(inst_in_v), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_rdy_low"}, 32'(s_ready), 32'd0);
    @(negedge clk);
    check({tag, "_v_edge1"}, 32'(inst_in_v), 32'd0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check({tag, "_v"}, 32'(inst_in_v), 32'd1);
      check({tag, "_data"}, 32'(inst_in), 32'(base + INST_W'(i)));
    end
    @(negedge clk);
    check({tag, "_v_end"}, 32'(inst_in_v), 32'd0);
    check({tag, "_hold"}, 32'(inst_in), 32'(base + INST_W'(len - 1)));
  endtask

  // Counts cycles with s_ready low, starting at the first negedge after the burst.
  task automatic check_exec(input string tag, input logic hold_valid, input int exp_cycles);
    int n;
    n = 0;
    s_valid = hold_valid;
    s_data  = 16'hDEAD;
    while (s_ready === 1'b0 && n < 200) begin
      if (inst_in_v !== 1'b0) check({tag, "_v_in_exec"}, 32'(inst_in_v), 32'd0);
      n++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check({tag, "_wait"}, 32'(n), 32'(exp_cycles));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    #12;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_inst_in_v", 32'(inst_in_v), 32'd0);
    check("rst_inst_in", 32'(inst_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: four back-to-back beats
    for (int i = 0; i < 4; i++) send(16'h00A0 + 16'(i), i == 3);
    check_burst("t1", 16'h00A0, 4);
    check_exec("t1", 1'b0, DELAY + 4 + GUARD);

    // 2: same program with 3-cycle gaps
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      send(16'h00A0 + 16'(i), i == 3);
    end
    check_burst("t2", 16'h00A0, 4);
    // 3: host holding s_valid during EXEC is ignored
    check_exec("t3", 1'b1, DELAY + 4 + GUARD);
    check("t3_not_busy_after", 32'(busy), 32'd0);

    // 4: DEPTH+3 beats, truncated to DEPTH
    for (int i = 0; i < DEPTH + 3; i++) begin
      send(16'h0100 + 16'(i), i == DEPTH + 2);
      if (i == DEPTH - 2) check("t4_err_before", 32'(err_len), 32'd0);
      if (i == DEPTH - 1) check("t4_err_set", 32'(err_len), 32'd1);
    end
    check_burst("t4", 16'h0100, DEPTH);
    check_exec("t4", 1'b0, DELAY + DEPTH + GUARD);
    check("t4_err_sticky", 32'(err_len), 32'd1);

    // 5: single-beat program
    send(16'h0055, 1'b1);
    check_burst("t5", 16'h0055, 1);
    check_exec("t5", 1'b0, DELAY + 1 + GUARD);
    check("t5_err_sticky", 32'(err_len), 32'd1);

    // 6: reset during the 2nd burst beat
    for (int i = 0; i < 4; i++) send(16'h00B0 + 16'(i), i == 3);
    repeat (3) @(negedge clk);
    check("t6_pre_v", 32'(inst_in_v), 32'd1);
    check("t6_pre_data", 32'(inst_in), 32'h00B1);
    #1 rst = 1'b0;
    #1;
    check("t6_async_v", 32'(inst_in_v), 32'd0);
    check("t6_async_rdy", 32'(s_ready), 32'd1);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_err", 32'(err_len), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    send(16'h00C0, 1'b0);
    send(16'h00C1, 1'b1);
    check_burst("t6", 16'h00C0, 2);
    check_exec("t6", 1'b0, DELAY + 2 + GUARD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
